// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART serial transmitter.
// Sends one frame per accepted request: a start bit (0), DATA_BITS data bits
// LSB first, an optional parity bit, then STOP_BITS stop bits (1). Bit timing
// comes from the external baud enable pulse `tick`. All registers update on
// the falling edge of clk_2.
//
// Ports:
//   clk_2    in   system clock (falling-edge active)
//   reset    in   asynchronous, active-high reset
//   tick     in   baud enable, one clk_2 cycle per bit period
//   send     in   transmit request, honoured only while ready=1
//   data_in  in   word to transmit, captured when send is accepted
//   txd      out  serial line, idles high
//   ready    out  1 = idle, a send will be accepted
//   busy     out  1 = frame pending or in progress
//   done     out  one-cycle pulse when the last stop bit completes
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for send
// LOAD   | word captured, line high until the next tick aligns the frame
// START  | start bit (0) on the line
// DATA   | data bit shift_q[0] on the line, bit_cnt counts sent bits
// PARITY | parity bit on the line
// STOP   | stop bit (1) on the line, stop_cnt counts stop periods

module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 txd,
    output logic                 ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic       ODD_BIT   = (PARITY_ODD != 0);

    state_t                 state_q,    state_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   parity_q,   parity_d;
    logic [3:0]             bit_cnt_q,  bit_cnt_d;
    logic [3:0]             stop_cnt_q, stop_cnt_d;
    logic                   txd_q,      txd_d;
    logic                   ready_q,    ready_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;

    // Outputs are computed for the next state so they come straight from
    // flops: the line never glitches and status flips on the same edge as
    // the state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // tick is deliberately ignored here, including the cycle in
                // which send is accepted; the frame aligns to the next tick.
                if (send) begin
                    shift_d    = data_in;
                    parity_d   = (^data_in) ^ ODD_BIT;
                    bit_cnt_d  = 4'd0;
                    stop_cnt_d = 4'd0;
                    state_d    = S_LOAD;
                    txd_d      = 1'b1;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_LOAD: begin
                if (tick) begin
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = 4'd0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        txd_d     = shift_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 4'd0;
                    txd_d      = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 4'd0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign txd   = txd_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. Four instances share the same stimulus:
//   inst0 8E1, inst1 8O1, inst2 8N1, inst3 8E2.
// A frame-level reference model predicts every output every cycle; a table
// of directed words is also checked bit by bit against hand-computed parity.

module tb_uart_tx_ctrl;

    logic       clk_2 = 1'b1;
    logic       reset = 1'b0;
    logic       tick  = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [3:0] txd_v, ready_v, busy_v, done_v;

    int n_tests = 0;
    int n_fail  = 0;

    int cfg_pen [4] = '{1, 1, 0, 1};
    int cfg_podd[4] = '{0, 1, 0, 0};
    int cfg_stop[4] = '{1, 1, 1, 2};

    int tick_mode = 0;
    int tick_cnt  = 0;
    bit chk_en    = 1'b0;

    int done_cnt[4] = '{0, 0, 0, 0};
    int exp_done[4] = '{0, 0, 0, 0};

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk_2(clk_2), .reset(reset), .tick(tick), .send(send), .data_in(data_in),
        .txd(txd_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk_2(clk_2), .reset(reset), .tick(tick), .send(send), .data_in(data_in),
        .txd(txd_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
        .clk_2(clk_2), .reset(reset), .tick(tick), .send(send), .data_in(data_in),
        .txd(txd_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk_2(clk_2), .reset(reset), .tick(tick), .send(send), .data_in(data_in),
        .txd(txd_v[3]), .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    initial forever #5 clk_2 = ~clk_2;

    // Baud tick: fixed period of 16 cycles, or random density in the soak phase.
    initial begin
        forever begin
            @(posedge clk_2);
            #1;
            if (tick_mode != 0) begin
                tick = ($urandom_range(0, 3) == 0);
            end else begin
                tick_cnt = (tick_cnt == 15) ? 0 : tick_cnt + 1;
                tick     = (tick_cnt == 0);
            end
        end
    end

    // ---------------- reference model: a frame is a list of line bits -------
    bit        m_active [4];
    bit        m_started[4];
    bit        m_done   [4];
    logic [15:0] m_frame[4];
    int        m_len    [4];
    int        m_idx    [4];

    function automatic int frame_len(int i);
        return 1 + 8 + cfg_pen[i] + cfg_stop[i];
    endfunction

    always @(negedge clk_2 or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_active[i]  = 1'b0;
                m_started[i] = 1'b0;
                m_done[i]    = 1'b0;
                m_idx[i]     = 0;
            end else begin
                m_done[i] = 1'b0;
                if (!m_active[i]) begin
                    if (send) begin
                        m_frame[i] = '1;
                        m_frame[i][0] = 1'b0;
                        for (int b = 0; b < 8; b++) m_frame[i][1 + b] = data_in[b];
                        if (cfg_pen[i] != 0)
                            m_frame[i][9] = (^data_in) ^ (cfg_podd[i] != 0);
                        m_len[i]     = frame_len(i);
                        m_active[i]  = 1'b1;
                        m_started[i] = 1'b0;
                    end
                end else if (tick) begin
                    if (!m_started[i]) begin
                        m_started[i] = 1'b1;
                        m_idx[i]     = 0;
                    end else begin
                        m_idx[i]++;
                        if (m_idx[i] == m_len[i]) begin
                            m_active[i] = 1'b0;
                            m_done[i]   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic model_txd(int i);
        if (!m_active[i] || !m_started[i]) return 1'b1;
        return m_frame[i][m_idx[i]];
    endfunction

    always @(posedge clk_2) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                logic [3:0] got, exp;
                got = {txd_v[i], ready_v[i], busy_v[i], done_v[i]};
                exp = {model_txd(i), !m_active[i], m_active[i], m_done[i]};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL model_cmp inst%0d t=%0t txd/ready/busy/done got=%b want=%b",
                             i, $time, got, exp);
                end
            end
        end
        for (int i = 0; i < 4; i++) if (done_v[i] === 1'b1) done_cnt[i]++;
    end

    // ---------------- directed checks ---------------------------------------
    task automatic check(string name, int inst, logic got, logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t got=%b want=%b", name, inst, $time, got, exp);
        end
    endtask

    // Returns 2 time units after a posedge whose following negedge sees tick=1.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk_2);
            #2;
            n++;
        end while (!tick && n < 100);
        n_tests++;
        if (!tick) begin
            n_fail++;
            $display("FAIL wait_tick timeout t=%0t got=no_tick want=tick", $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        bit         inject;
        int         abort_k;
    } vec_t;

    vec_t vecs[8];

    function automatic logic exp_bit(vec_t v, int i, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return v.data[k - 1];
        if (cfg_pen[i] != 0 && k == 9) return (cfg_podd[i] != 0) ? ~v.par_even : v.par_even;
        return 1'b1;
    endfunction

    task automatic run_frame(vec_t v);
        @(posedge clk_2);
        #1;
        send    = 1'b1;
        data_in = v.data;
        @(negedge clk_2);
        #1;
        send    = 1'b0;
        data_in = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            check("accept_busy", i, busy_v[i], 1'b1);
            check("accept_ready", i, ready_v[i], 1'b0);
            n_tests++;
            if (done_cnt[i] != exp_done[i]) begin
                n_fail++;
                $display("FAIL done_count inst%0d got=%0d want=%0d", i, done_cnt[i], exp_done[i]);
            end
        end
        wait_tick();
        for (int i = 0; i < 4; i++) check("load_line_high", i, txd_v[i], 1'b1);
        for (int k = 0; k < 12; k++) begin
            wait_tick();
            for (int i = 0; i < 4; i++)
                if (k < frame_len(i)) check("frame_bit", i, txd_v[i], exp_bit(v, i, k));
            if (v.inject && k == 3) begin
                send    = 1'b1;
                data_in = 8'hFF;
            end else begin
                send = 1'b0;
            end
            if (v.abort_k != 0 && k == v.abort_k) begin
                #1 reset = 1'b1;
                #1;
                for (int i = 0; i < 4; i++) begin
                    check("rst_txd", i, txd_v[i], 1'b1);
                    check("rst_busy", i, busy_v[i], 1'b0);
                    check("rst_ready", i, ready_v[i], 1'b1);
                end
                repeat (3) @(posedge clk_2);
                #1 reset = 1'b0;
                return;
            end
        end
        for (int i = 0; i < 4; i++) exp_done[i]++;
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, par_even: 1'b0, inject: 1'b1, abort_k: 0};
        vecs[1] = '{data: 8'h07, par_even: 1'b1, inject: 1'b0, abort_k: 0};
        vecs[2] = '{data: 8'hA3, par_even: 1'b0, inject: 1'b0, abort_k: 0};
        vecs[3] = '{data: 8'h3C, par_even: 1'b0, inject: 1'b0, abort_k: 0};
        vecs[4] = '{data: 8'hC9, par_even: 1'b0, inject: 1'b0, abort_k: 4};
        vecs[5] = '{data: 8'h81, par_even: 1'b0, inject: 1'b0, abort_k: 0};
        vecs[6] = '{data: 8'hFE, par_even: 1'b1, inject: 1'b0, abort_k: 0};
        vecs[7] = '{data: 8'h01, par_even: 1'b1, inject: 1'b0, abort_k: 0};

        #1 reset = 1'b1;
        #2;
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("reset_txd", i, txd_v[i], 1'b1);
            check("reset_ready", i, ready_v[i], 1'b1);
            check("reset_busy", i, busy_v[i], 1'b0);
            check("reset_done", i, done_v[i], 1'b0);
        end
        repeat (3) @(posedge clk_2);
        #1 reset = 1'b0;

        repeat (50) @(posedge clk_2);
        #2;
        for (int i = 0; i < 4; i++) check("idle_txd", i, txd_v[i], 1'b1);

        for (int n = 0; n < 8; n++) run_frame(vecs[n]);

        repeat (40) @(posedge clk_2);
        #2;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (done_cnt[i] != exp_done[i]) begin
                n_fail++;
                $display("FAIL final_done_count inst%0d got=%0d want=%0d",
                         i, done_cnt[i], exp_done[i]);
            end
        end

        // Soak: random tick density, random requests and data, one mid-run reset.
        tick_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_2);
            #1;
            send    = ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
            if (c == 2000) begin
                #2 reset = 1'b1;
                #4 reset = 1'b0;
            end
        end
        send = 1'b0;
        repeat (5) @(posedge clk_2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
